// File: rtl/mc_pkg.sv
// mc_pkg: shared state encodings, opcode patterns, ALU/SignOp and fault codes for the multicycle sequencer
package mc_pkg;
  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EX_R = 4'd3,
                         S_EX_I = 4'd4, S_WB_ALU = 4'd5, S_ADDR = 4'd6, S_MEM_RD = 4'd7,
                         S_WB_MEM = 4'd8, S_MEM_WR = 4'd9, S_BR_CB = 4'd10, S_BR_U = 4'd11,
                         S_FAULT = 4'd12;
  typedef enum logic [2:0] {CL_R, CL_I, CL_LD, CL_ST, CL_CB, CL_B, CL_ILL} cls_t;
  localparam logic [10:0] OP_ADD  = 11'b10001011000, OP_SUB  = 11'b11001011000,
                          OP_AND  = 11'b10001010000, OP_ORR  = 11'b10101010000,
                          OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000,
                          OP_ADDI = 11'b10010001000, OP_SUBI = 11'b11010001000,
                          OP_CBZ  = 11'b10110100000, OP_B    = 11'b00010100000;
  localparam logic [10:0] MASK_I = 11'b11111111110, MASK_CB = 11'b11111111000, MASK_B = 11'b11111100000;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_ORR = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_PASSB = 4'b0111;
  localparam logic [1:0] SE_I = 2'b00, SE_D = 2'b01, SE_B = 2'b10, SE_CB = 2'b11;
  localparam logic [1:0] FC_NONE = 2'b00, FC_ILLEGAL = 2'b01, FC_TIMEOUT = 2'b10;
  function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat, input logic [10:0] mask);
    return (op & mask) == pat;
  endfunction
endpackage

// File: rtl/mc_if.sv
// mc_if: control bundle between the sequencer (master) and the LEGv8 datapath (slave)
interface mc_if #(parameter int CNT_W = 32);
  logic start;
  logic [10:0] opcode;
  logic zero;
  logic mem_ready;
  logic ir_write, pc_write, pc_sel, reg2loc, alu_src;
  logic [3:0] alu_op;
  logic [1:0] sign_op;
  logic mem_read, mem_write, mem_to_reg, reg_write;
  logic busy, retire, fault;
  logic [1:0] fault_code;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input  start, opcode, zero, mem_ready,
    output ir_write, pc_write, pc_sel, reg2loc, alu_src, alu_op, sign_op,
           mem_read, mem_write, mem_to_reg, reg_write, busy, retire, fault, fault_code, instr_count
  );
  modport slave (
    output start, opcode, zero, mem_ready,
    input  ir_write, pc_write, pc_sel, reg2loc, alu_src, alu_op, sign_op,
           mem_read, mem_write, mem_to_reg, reg_write, busy, retire, fault, fault_code, instr_count
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode to instruction class and ALU code
module mc_decode
  import mc_pkg::*;
(
  input  logic [10:0] opcode,
  output cls_t        cls,
  output logic [3:0]  alu_op,
  output logic        illegal
);
  always_comb begin
    cls = (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) ? CL_R :
          (op_match(opcode, OP_ADDI, MASK_I) || op_match(opcode, OP_SUBI, MASK_I)) ? CL_I :
          opcode == OP_LDUR ? CL_LD :
          opcode == OP_STUR ? CL_ST :
          op_match(opcode, OP_CBZ, MASK_CB) ? CL_CB :
          op_match(opcode, OP_B, MASK_B) ? CL_B : CL_ILL;
    alu_op = (opcode == OP_SUB || op_match(opcode, OP_SUBI, MASK_I)) ? ALU_SUB :
             opcode == OP_AND ? ALU_AND :
             opcode == OP_ORR ? ALU_ORR : ALU_ADD;
    illegal = cls == CL_ILL;
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle LEGv8 sequencer with memory wait timeout and retired-instruction counter
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input logic CLK,
  input logic reset,
  mc_if.master bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  logic [3:0] state, nxt;
  cls_t cls, cls_q;
  logic [3:0] dec_alu, alu_q;
  logic illegal;
  logic [WW-1:0] wcnt;
  logic [CNT_W-1:0] cnt;
  logic [1:0] fcode;
  logic in_mem, timeout;
  mc_decode u_dec (.opcode(bus.opcode), .cls(cls), .alu_op(dec_alu), .illegal(illegal));
  assign in_mem = state == S_MEM_RD || state == S_MEM_WR;
  assign timeout = !bus.mem_ready && wcnt == WW'(MEM_TIMEOUT);
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = bus.start ? S_FETCH : S_IDLE;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = illegal ? S_FAULT : cls == CL_R ? S_EX_R : cls == CL_I ? S_EX_I :
                      cls == CL_CB ? S_BR_CB : cls == CL_B ? S_BR_U : S_ADDR;
      S_EX_R, S_EX_I: nxt = S_WB_ALU;
      S_ADDR:   nxt = cls_q == CL_LD ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: nxt = bus.mem_ready ? S_WB_MEM : timeout ? S_FAULT : S_MEM_RD;
      S_MEM_WR: nxt = bus.mem_ready ? S_FETCH : timeout ? S_FAULT : S_MEM_WR;
      S_WB_ALU, S_WB_MEM, S_BR_CB, S_BR_U: nxt = S_FETCH;
      default:  nxt = state;
    endcase
  end
  always_comb begin
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel = 1'b0;
    bus.reg2loc = 1'b0;
    bus.alu_src = 1'b0;
    bus.alu_op = ALU_AND;
    bus.sign_op = SE_I;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write = 1'b0;
    bus.retire = 1'b0;
    case (state)
      S_FETCH:  bus.ir_write = 1'b1;
      S_DECODE: bus.reg2loc = cls == CL_ST || cls == CL_CB;
      S_EX_R:   bus.alu_op = alu_q;
      S_EX_I: begin
        bus.alu_src = 1'b1;
        bus.alu_op = alu_q;
      end
      S_WB_ALU: begin
        bus.alu_op = alu_q;
        bus.alu_src = cls_q == CL_I;
        bus.reg_write = 1'b1;
        bus.pc_write = 1'b1;
        bus.retire = 1'b1;
      end
      S_ADDR, S_MEM_RD, S_MEM_WR: begin
        bus.alu_src = 1'b1;
        bus.sign_op = SE_D;
        bus.alu_op = ALU_ADD;
        bus.mem_read = state == S_MEM_RD;
        bus.mem_write = state == S_MEM_WR;
        bus.reg2loc = state == S_MEM_WR;
        bus.pc_write = state == S_MEM_WR && bus.mem_ready;
        bus.retire = state == S_MEM_WR && bus.mem_ready;
      end
      S_WB_MEM: begin
        bus.mem_read = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.reg_write = 1'b1;
        bus.pc_write = 1'b1;
        bus.retire = 1'b1;
      end
      S_BR_CB: begin
        bus.reg2loc = 1'b1;
        bus.alu_op = ALU_PASSB;
        bus.sign_op = SE_CB;
        bus.pc_write = 1'b1;
        bus.pc_sel = bus.zero;
        bus.retire = 1'b1;
      end
      S_BR_U: begin
        bus.sign_op = SE_B;
        bus.pc_write = 1'b1;
        bus.pc_sel = 1'b1;
        bus.retire = 1'b1;
      end
      default: ;
    endcase
  end
  assign bus.busy = state != S_IDLE && state != S_FAULT;
  assign bus.fault = state == S_FAULT;
  assign bus.fault_code = fcode;
  assign bus.instr_count = cnt;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cls_q <= CL_R;
      alu_q <= ALU_AND;
      wcnt <= '0;
      cnt <= '0;
      fcode <= FC_NONE;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        cls_q <= cls;
        alu_q <= dec_alu;
      end
      wcnt <= state == S_ADDR ? '0 : (in_mem && !bus.mem_ready) ? wcnt + WW'(1) : wcnt;
      if (bus.retire) cnt <= cnt + CNT_W'(1);
      // only DECODE faults on the opcode; every other entry into FAULT is a memory timeout
      if (nxt == S_FAULT && state != S_FAULT) fcode <= state == S_DECODE ? FC_ILLEGAL : FC_TIMEOUT;
    end
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench; the driver queues expected retire/fault events, a negedge monitor checks them
module tb_mc_control;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;
  mc_if #(.CNT_W(32)) bus ();
  mc_control #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (.CLK(CLK), .reset(reset), .bus(bus));
  typedef struct {
    int kind;
    int lat;
    logic pc_sel, reg_write, mem_to_reg, mem_write;
    logic [3:0] alu_op;
    logic [1:0] code;
    int cnt;
  } exp_t;
  typedef struct {
    logic [10:0] op;
    int w;
    logic z;
    exp_t e;
  } ins_t;
  exp_t sbq[$];
  ins_t pq[$];
  ins_t cur;
  int k, nret, checks, errors, cyc, fcyc;
  logic prev_ir, fault_seen;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [10:0] op, input int w, input logic z, input int kind, input int lat,
                     input logic ps, input logic rw, input logic m2r, input logic mw,
                     input logic [3:0] alu, input logic [1:0] code);
    ins_t i;
    i.op = op; i.w = w; i.z = z;
    i.e.kind = kind; i.e.lat = lat; i.e.pc_sel = ps; i.e.reg_write = rw;
    i.e.mem_to_reg = m2r; i.e.mem_write = mw; i.e.alu_op = alu; i.e.code = code;
    i.e.cnt = nret;
    if (kind == 0) nret++;
    pq.push_back(i);
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
    if (bus.ir_write && pq.size() > 0) begin
      cur = pq.pop_front();
      bus.opcode = cur.op;
      bus.zero = cur.z;
      k = 0;
      if (cur.e.kind != 2) sbq.push_back(cur.e);
    end
    bus.mem_ready = 1'b0;
    if ((bus.mem_read && !bus.mem_to_reg) || bus.mem_write) begin
      bus.mem_ready = k >= cur.w;
      k++;
    end
  endtask
  task automatic run_until_fault(input int budget, input string name);
    int n = 0;
    while (!bus.fault && n < budget) begin
      step();
      n++;
    end
    chk({name, "_fault_reached"}, {31'd0, bus.fault}, 32'd1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.mem_ready = 1'b0;
    pq.delete();
    sbq.delete();
    nret = 0;
    @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    exp_t e;
    int lat;
    forever begin
      @(negedge CLK);
      cyc++;
      if (reset) begin
        prev_ir = 1'b0;
        fault_seen = 1'b0;
      end else begin
        if (bus.ir_write) begin
          fcyc = cyc;
          chk("ir_write_pulse", {31'd0, prev_ir}, 32'd0);
          chk("fetch_busy", {31'd0, bus.busy}, 32'd1);
        end
        prev_ir = bus.ir_write;
        if (bus.retire || (bus.fault && !fault_seen)) begin
          if (bus.fault) fault_seen = 1'b1;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: retire=%0b fault=%0b, scoreboard empty", bus.retire, bus.fault);
          end else begin
            e = sbq.pop_front();
            lat = cyc - fcyc + 1;
            chk("latency", lat, e.lat);
            if (e.kind == 1) begin
              chk("fault_code", {30'd0, bus.fault_code}, {30'd0, e.code});
              chk("fault_pc_write", {31'd0, bus.pc_write}, 32'd0);
              chk("fault_busy", {31'd0, bus.busy}, 32'd0);
            end else begin
              chk("pc_write", {31'd0, bus.pc_write}, 32'd1);
              chk("pc_sel", {31'd0, bus.pc_sel}, {31'd0, e.pc_sel});
              chk("reg_write", {31'd0, bus.reg_write}, {31'd0, e.reg_write});
              chk("mem_to_reg", {31'd0, bus.mem_to_reg}, {31'd0, e.mem_to_reg});
              chk("mem_write", {31'd0, bus.mem_write}, {31'd0, e.mem_write});
              chk("alu_op", {28'd0, bus.alu_op}, {28'd0, e.alu_op});
              chk("instr_count", bus.instr_count, e.cnt);
            end
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0; fcyc = 0; nret = 0; k = 0;
    bus.start = 1'b0; bus.opcode = 11'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ir_write", {31'd0, bus.ir_write}, 32'd0);
    chk("rst_pc_write", {31'd0, bus.pc_write}, 32'd0);
    chk("rst_mem_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("rst_reg_write", {31'd0, bus.reg_write}, 32'd0);
    chk("rst_fault", {29'd0, bus.fault, bus.fault_code}, 32'd0);
    chk("rst_instr_count", bus.instr_count, 32'd0);
    chk("rst_alu_op", {28'd0, bus.alu_op}, 32'd0);
    reset = 1'b0;
    //   op             w   z  kind lat ps rw m2r mw alu      code
    add(11'b10001011000, 0, 0, 0, 4, 0, 1, 0, 0, 4'b0010, 2'b00);
    add(11'b11001011000, 0, 0, 0, 4, 0, 1, 0, 0, 4'b0110, 2'b00);
    add(11'b10001010000, 0, 0, 0, 4, 0, 1, 0, 0, 4'b0000, 2'b00);
    add(11'b10101010000, 0, 0, 0, 4, 0, 1, 0, 0, 4'b0001, 2'b00);
    add(11'b10010001001, 0, 0, 0, 4, 0, 1, 0, 0, 4'b0010, 2'b00);
    add(11'b11010001000, 0, 0, 0, 4, 0, 1, 0, 0, 4'b0110, 2'b00);
    add(11'b11111000010, 3, 0, 0, 8, 0, 1, 1, 0, 4'b0000, 2'b00);
    add(11'b11111000010, 0, 0, 0, 5, 0, 1, 1, 0, 4'b0000, 2'b00);
    add(11'b11111000000, 0, 0, 0, 4, 0, 0, 0, 1, 4'b0010, 2'b00);
    add(11'b11111000000, 2, 0, 0, 6, 0, 0, 0, 1, 4'b0010, 2'b00);
    add(11'b10110100101, 0, 1, 0, 3, 1, 0, 0, 0, 4'b0111, 2'b00);
    add(11'b10110100000, 0, 0, 0, 3, 0, 0, 0, 0, 4'b0111, 2'b00);
    add(11'b00010111111, 0, 0, 0, 3, 1, 0, 0, 0, 4'b0000, 2'b00);
    add(11'b11111000010, 15, 0, 0, 20, 0, 1, 1, 0, 4'b0000, 2'b00);
    add(11'b11111111111, 0, 0, 1, 3, 0, 0, 0, 0, 4'b0000, 2'b01);
    bus.start = 1'b1;
    step();
    run_until_fault(400, "prog1");
    repeat (3) step();
    chk("illegal_pc_write_after", {31'd0, bus.pc_write}, 32'd0);
    chk("illegal_fault_code_held", {30'd0, bus.fault_code}, 32'd1);
    chk("prog1_instr_count", bus.instr_count, 32'd14);
    chk("prog1_drain", sbq.size(), 32'd0);
    do_reset();
    add(11'b11111000010, 100, 0, 1, 20, 0, 0, 0, 0, 4'b0000, 2'b10);
    bus.start = 1'b1;
    step();
    run_until_fault(100, "timeout");
    repeat (2) step();
    chk("timeout_drain", sbq.size(), 32'd0);
    do_reset();
    add(11'b10001011000, 0, 0, 0, 4, 0, 1, 0, 0, 4'b0010, 2'b00);
    add(11'b11111000000, 100, 0, 2, 0, 0, 0, 0, 1, 4'b0010, 2'b00);
    bus.start = 1'b1;
    step();
    n = 0;
    while (!bus.mem_write && n < 50) begin
      step();
      n++;
    end
    chk("mem_wr_reached", {31'd0, bus.mem_write}, 32'd1);
    step();
    step();
    chk("pre_reset_count", bus.instr_count, 32'd1);
    #2;
    reset = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("async_mem_write_drop", {31'd0, bus.mem_write}, 32'd0);
    chk("async_busy_drop", {31'd0, bus.busy}, 32'd0);
    chk("async_instr_count", bus.instr_count, 32'd0);
    chk("async_pc_write", {31'd0, bus.pc_write}, 32'd0);
    pq.delete();
    sbq.delete();
    @(posedge CLK);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_writes", {30'd0, bus.pc_write, bus.reg_write}, 32'd0);
      chk("post_reset_idle", {31'd0, bus.busy}, 32'd0);
    end
    chk("final_drain", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multicycle sequencer for the LEGv8 datapath. It splits each instruction into FETCH / DECODE / EXEC / MEM / WB steps and drives the datapath control lines and PC/IR write enables from a Moore FSM. It replaces the single-cycle SC_Control so that a variable-latency data memory can be shared over several cycles. It also counts retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready in one MEM state before the FSM faults.
CNT_W, 32, width of the retired-instruction counter.

Ports:
CLK  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
start  in  1  in IDLE, begins execution at the datapath's current PC.
opcode  in  11  instruction[31:21] from the datapath IR; valid from DECODE onward.
zero  in  1  ALU Zero flag, sampled in BR_CB.
mem_ready  in  1  data memory access complete; sampled in MEM_RD and MEM_WR.
ir_write  out  1  IR load enable.
pc_write  out  1  PC load enable.
pc_sel  out  1  0 = PC+4, 1 = PC + branch offset.
reg2loc  out  1  RB select, same meaning as SC_Control.
alu_src  out  1  1 = sign-extended immediate.
alu_op  out  4  ALUCtrl code.
sign_op  out  2  SignExtender select.
mem_read  out  1  data memory read strobe.
mem_write  out  1  data memory write strobe.
mem_to_reg  out  1  1 = write-back from memory.
reg_write  out  1  register file write enable.
busy  out  1  high in every state except IDLE and FAULT.
retire  out  1  one-cycle pulse in an instruction's final state.
fault  out  1  high in FAULT.
fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.
instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset values: state = IDLE, all outputs 0, instr_count 0, fault_code 00.
- Instruction classes, decoded in DECODE and latched:
  - R: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - I: ADDI/SUBI, 1001000100x / 1101000100x.
  - LD: LDUR 11111000010.
  - ST: STUR 11111000000.
  - CB: CBZ 10110100xxx.
  - B: 000101xxxxx.
  - Anything else goes to FAULT with code 01.
- ALU codes: AND 0000, ORR 0001, ADD 0010, SUB 0110, PassB 0111.
- sign_op: I 00, D 01, B 10, CB 11.
- FSM and state outputs (outputs not listed are 0):
  - IDLE: start → FETCH.
  - FETCH: ir_write=1 → DECODE.
  - DECODE: reg2loc=1 for ST and CB; branches to EX_R, EX_I, ADDR, BR_CB, BR_U or FAULT.
  - EX_R: alu_op by opcode → WB_ALU.
  - EX_I: alu_src=1, sign_op=00 → WB_ALU.
  - WB_ALU: alu_op/alu_src held from EX, reg_write=1, pc_write=1, pc_sel=0, retire=1 → FETCH.
  - ADDR: alu_src=1, sign_op=01, alu_op=0010; → MEM_RD for LD, MEM_WR for ST.
  - MEM_RD: mem_read=1; ADDR ALU controls held; wait for mem_ready → WB_MEM.
  - WB_MEM: mem_to_reg=1, reg_write=1, pc_write=1, retire=1; mem_read held → FETCH.
  - MEM_WR: mem_write=1, reg2loc=1, ADDR ALU controls held; on mem_ready: pc_write=1, retire=1 → FETCH.
  - BR_CB: reg2loc=1, alu_op=0111, sign_op=11, pc_write=1, pc_sel=zero, retire=1 → FETCH.
  - BR_U: sign_op=10, pc_write=1, pc_sel=1, retire=1 → FETCH.
  - FAULT: terminal until reset.
- Latency (cycles per instruction): R/I 4; CB/B 3; STUR 4+w; LDUR 5+w, where w = cycles with mem_ready low.
- Memory wait timing:
  - A wait counter clears on entry to MEM_RD or MEM_WR.
  - It increments each cycle mem_ready is low.
  - If mem_ready is still low in the cycle where the count equals MEM_TIMEOUT, the FSM goes to FAULT with code 10.
  - mem_ready high in the first MEM cycle means zero wait.
- Counter and status rules:
  - instr_count increments on retire and wraps modulo 2^CNT_W.
  - start is ignored outside IDLE.
- Reset mid-instruction: async return to IDLE; all strobes drop immediately; no partial PC/register write is issued after reset deasserts.

Decomposition:
- Package mc_pkg holds:
  - state enum;
  - opcode constants and masks;
  - ALU codes;
  - SignOp codes;
  - fault codes.
- Sub-module mc_decode: combinational opcode → class / alu_op / illegal.
- The FSM, wait counter and instruction counter stay in mc_control.

Test Plan:
- Reset and start: reset high, then start=1 → FETCH next cycle; ir_write=1 for exactly one cycle; busy=1.
- ADD (opcode 10001011000): 4 cycles to retire; WB_ALU shows alu_op=0010, reg_write=1, pc_sel=0; instr_count 0→1.
- LDUR with mem_ready low 3 cycles: mem_read held 4 cycles, then WB_MEM with mem_to_reg=1; 8 cycles total; STUR with mem_ready=1 takes 4 cycles with mem_write=1 and reg_write=0.
- CBZ: with zero=1, pc_sel=1; with zero=0, pc_sel=0; pc_write=1 in BR_CB; 3 cycles; B gives pc_sel=1 in 3 cycles.
- Illegal opcode 11111111111 → FAULT after DECODE, fault_code=01, no further pc_write; mem_ready held low 16+ cycles → fault_code=10.
- Async reset asserted mid-MEM_WR: mem_write drops without waiting for a clock edge; state=IDLE; instr_count=0.
